// File: rtl/seg_scan_reader_pkg.sv
// seg_scan_reader_pkg: character codes, segment patterns and FSM state type shared by the scan reader.
package seg_scan_reader_pkg;
   localparam logic [2:0] C_H     = 3'b000;
   localparam logic [2:0] C_E     = 3'b001;
   localparam logic [2:0] C_L     = 3'b010;
   localparam logic [2:0] C_O     = 3'b011;
   localparam logic [2:0] C_BLANK = 3'b111;
   // Segment patterns are {g,f,e,d,c,b,a}, active-low.
   localparam logic [6:0] P_H     = 7'b0001001;
   localparam logic [6:0] P_E     = 7'b0000110;
   localparam logic [6:0] P_L     = 7'b1000111;
   localparam logic [6:0] P_O     = 7'b1000000;
   localparam logic [6:0] P_BLANK = 7'b1111111;
   localparam int STABLE_CNT_DEF = 4;
   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_LOCKED} state_t;
   function automatic logic is_onehot4(input logic [3:0] d);
      return d != 4'd0 && (d & (d - 4'd1)) == 4'd0;
   endfunction
endpackage

// File: rtl/seg_scan_reader_decode.sv
// seg_char_decode: maps an active-low 7-segment pattern to a 3-bit character code and an unknown-pattern flag.
module seg_char_decode
   import seg_scan_reader_pkg::*;
(
   input  logic [6:0] i_seg,
   output logic [2:0] o_code,
   output logic       o_err
);
   always_comb begin
      o_code = i_seg == P_H ? C_H : i_seg == P_E ? C_E : i_seg == P_L ? C_L : i_seg == P_O ? C_O : C_BLANK;
      o_err  = !(i_seg inside {P_H, P_E, P_L, P_O, P_BLANK});
   end
endmodule

// File: rtl/seg_scan_reader.sv
// seg_scan_reader: debounces a multiplexed 4-digit 7-segment scan into decoded frames with a valid/ready handshake.
module seg_scan_reader
   import seg_scan_reader_pkg::*;
#(
   parameter int STABLE_CNT = STABLE_CNT_DEF
)(
   input  logic        CLOCK_50,
   input  logic        KEY0,
   input  logic [6:0]  SEG,
   input  logic [3:0]  DIG,
   input  logic        FRAME_READY,
   output logic [11:0] CHAR,
   output logic [3:0]  ERR,
   output logic        FRAME_VALID,
   output logic        OVR
);
   state_t      r_state;
   logic [10:0] r_sample;
   logic [3:0]  r_cnt;
   logic [3:0]  r_mask;
   logic [11:0] r_slot_code;
   logic [3:0]  r_slot_err;
   logic        w_onehot;
   logic        w_same;
   logic        w_capture;
   logic        w_complete;
   logic [3:0]  w_sel;
   logic [3:0]  w_mask_nxt;
   logic [2:0]  w_code;
   logic        w_err;
   logic [11:0] w_slot_code;
   logic [3:0]  w_slot_err;

   // Decoding the stored sample is safe: a capture only happens when the live bus equals it.
   seg_char_decode u_decode (
      .i_seg  (r_sample[6:0]),
      .o_code (w_code),
      .o_err  (w_err)
   );

   always_comb begin
      w_onehot    = is_onehot4(DIG);
      w_same      = {DIG, SEG} == r_sample;
      w_sel       = r_sample[10:7];
      w_capture   = r_state == ST_SETTLE && w_same && (r_cnt + 4'd1) == 4'(STABLE_CNT);
      w_mask_nxt  = r_mask | w_sel;
      w_complete  = w_capture && &w_mask_nxt;
      w_slot_code = r_slot_code;
      w_slot_err  = r_slot_err;
      for (int i = 0; i < 4; i++) begin
         if (w_sel[i]) begin
            w_slot_code[3*i +: 3] = w_code;
            w_slot_err[i]         = w_err;
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge KEY0) begin
      if (!KEY0) begin
         r_state     <= ST_IDLE;
         r_sample    <= '0;
         r_cnt       <= '0;
         r_mask      <= '0;
         r_slot_code <= '1;
         r_slot_err  <= '0;
         CHAR        <= '1;
         ERR         <= '0;
         FRAME_VALID <= 1'b0;
         OVR         <= 1'b0;
      end else begin
         if (w_capture) begin
            r_state     <= ST_LOCKED;
            r_cnt       <= r_cnt + 4'd1;
            r_slot_code <= w_slot_code;
            r_slot_err  <= w_slot_err;
            r_mask      <= w_complete ? 4'd0 : w_mask_nxt;
         end else if (r_state == ST_IDLE || !w_same) begin
            // Any bus change, including a segment glitch mid-window, restarts settling.
            r_state  <= w_onehot ? ST_SETTLE : ST_IDLE;
            r_sample <= w_onehot ? {DIG, SEG} : r_sample;
            r_cnt    <= w_onehot ? 4'd1 : 4'd0;
         end else if (r_state == ST_SETTLE) begin
            r_cnt <= r_cnt + 4'd1;
         end
         if (w_complete) begin
            if (!FRAME_VALID || FRAME_READY) begin
               CHAR        <= w_slot_code;
               ERR         <= w_slot_err;
               FRAME_VALID <= 1'b1;
            end else begin
               OVR <= 1'b1;
            end
         end else if (FRAME_VALID && FRAME_READY) begin
            FRAME_VALID <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_seg_scan_reader.sv
// tb_seg_scan_reader: table-driven directed check of settling, frame handshake, overflow and async reset.
module tb_seg_scan_reader;
   localparam logic [6:0] H   = 7'b0001001;
   localparam logic [6:0] E   = 7'b0000110;
   localparam logic [6:0] L   = 7'b1000111;
   localparam logic [6:0] O   = 7'b1000000;
   localparam logic [6:0] BAD = 7'b0101010;
   localparam logic [6:0] BLK = 7'b1111111;
   localparam int RST_IDX = 25;

   typedef struct {
      logic [3:0]  dig;
      logic [6:0]  seg;
      logic        rdy;
      int          n;
      logic        fv;
      logic [11:0] ch;
      logic [3:0]  er;
      logic        ov;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [6:0]  seg = BLK;
   logic [3:0]  dig = 4'd0;
   logic        rdy = 1'b0;
   logic [11:0] ch;
   logic [3:0]  er;
   logic        fv;
   logic        ov;
   int          checks = 0;
   int          errors = 0;
   vec_t        q[$];

   always #5 clk = ~clk;

   seg_scan_reader #(.STABLE_CNT(4)) dut (
      .CLOCK_50    (clk),
      .KEY0        (rst_n),
      .SEG         (seg),
      .DIG         (dig),
      .FRAME_READY (rdy),
      .CHAR        (ch),
      .ERR         (er),
      .FRAME_VALID (fv),
      .OVR         (ov)
   );

   task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic efv, input logic [11:0] ech, input logic [3:0] eer, input logic eov);
      chk({tag, " valid"}, {11'd0, fv}, {11'd0, efv});
      chk({tag, " char"}, ch, ech);
      chk({tag, " err"}, {8'd0, er}, {8'd0, eer});
      chk({tag, " ovr"}, {11'd0, ov}, {11'd0, eov});
   endtask

   task automatic add(input logic [3:0] d, input logic [6:0] s, input logic r, input int n,
                      input logic efv, input logic [11:0] ech, input logic [3:0] eer, input logic eov);
      vec_t v;
      v = '{d, s, r, n, efv, ech, eer, eov};
      q.push_back(v);
   endtask

   initial begin
      add(4'b0001, H,   1, 8, 0, 12'hFFF, 4'h0, 0);
      add(4'b0010, E,   1, 8, 0, 12'hFFF, 4'h0, 0);
      add(4'b0100, L,   1, 8, 0, 12'hFFF, 4'h0, 0);
      add(4'b1000, O,   1, 4, 1, 12'h688, 4'h0, 0);
      add(4'b1000, O,   1, 4, 0, 12'h688, 4'h0, 0);
      add(4'b0010, H,   1, 3, 0, 12'h688, 4'h0, 0);
      add(4'b0000, BLK, 1, 2, 0, 12'h688, 4'h0, 0);
      add(4'b0001, E,   1, 3, 0, 12'h688, 4'h0, 0);
      add(4'b0001, L,   1, 8, 0, 12'h688, 4'h0, 0);
      add(4'b0100, BAD, 1, 6, 0, 12'h688, 4'h0, 0);
      add(4'b1000, H,   1, 8, 0, 12'h688, 4'h0, 0);
      add(4'b0010, E,   1, 4, 1, 12'h1CA, 4'h4, 0);
      add(4'b0010, E,   1, 4, 0, 12'h1CA, 4'h4, 0);
      add(4'b0001, E,   0, 8, 0, 12'h1CA, 4'h4, 0);
      add(4'b0010, E,   0, 8, 0, 12'h1CA, 4'h4, 0);
      add(4'b0100, E,   0, 8, 0, 12'h1CA, 4'h4, 0);
      add(4'b1000, E,   0, 8, 1, 12'h249, 4'h0, 0);
      add(4'b0001, H,   0, 8, 1, 12'h249, 4'h0, 0);
      add(4'b0010, H,   0, 8, 1, 12'h249, 4'h0, 0);
      add(4'b0100, H,   0, 8, 1, 12'h249, 4'h0, 0);
      add(4'b1000, H,   0, 8, 1, 12'h249, 4'h0, 1);
      add(4'b1000, H,   1, 1, 0, 12'h249, 4'h0, 1);
      add(4'b0001, L,   1, 8, 0, 12'h249, 4'h0, 1);
      add(4'b0010, L,   1, 8, 0, 12'h249, 4'h0, 1);
      add(4'b0100, L,   1, 8, 0, 12'h249, 4'h0, 1);
      add(4'b1000, O,   1, 8, 0, 12'hFFF, 4'h0, 0);
      add(4'b0001, H,   0, 8, 0, 12'hFFF, 4'h0, 0);
      add(4'b0010, H,   0, 8, 0, 12'hFFF, 4'h0, 0);
      add(4'b0100, H,   0, 8, 1, 12'h600, 4'h0, 0);
      add(4'b0001, E,   0, 8, 1, 12'h600, 4'h0, 0);
      add(4'b0010, E,   0, 8, 1, 12'h600, 4'h0, 0);
      add(4'b0100, E,   0, 8, 1, 12'h600, 4'h0, 0);
      add(4'b1000, E,   0, 3, 1, 12'h600, 4'h0, 0);
      add(4'b1000, E,   1, 1, 1, 12'h249, 4'h0, 0);
      add(4'b1000, E,   1, 1, 0, 12'h249, 4'h0, 0);

      repeat (2) @(negedge clk);
      chk_all("reset", 1'b0, 12'hFFF, 4'h0, 1'b0);
      rst_n = 1'b1;
      foreach (q[i]) begin
         if (i == RST_IDX) begin
            #2 rst_n = 1'b0;
            #1 chk_all("midreset", 1'b0, 12'hFFF, 4'h0, 1'b0);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
         end
         dig = q[i].dig;
         seg = q[i].seg;
         rdy = q[i].rdy;
         repeat (q[i].n) @(negedge clk);
         chk_all($sformatf("v%0d", i), q[i].fv, q[i].ch, q[i].er, q[i].ov);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/seg_scan_reader.md
SEG_SCAN_READER -- requirements
Module: seg_scan_reader

Interface
REQ-001 Parameter STABLE_CNT, default 4: consecutive identical samples required to accept a digit (legal range 2..15).
REQ-002 CLOCK_50  input  1  sole clock; all state changes on its rising edge.
REQ-003 KEY0  input  1  reset; asynchronous assertion, active-low.
REQ-004 SEG  input  7  multiplexed segment bus {g,f,e,d,c,b,a}, active-low (0 = lit); synchronous to CLOCK_50.
REQ-005 DIG  input  4  digit select, one-hot, 1 = digit active; any non-one-hot value means bus idle.
REQ-006 FRAME_READY  input  1  consumer accepts the frame in any cycle where FRAME_VALID=1 and FRAME_READY=1.
REQ-007 CHAR  output  12  {digit3,digit2,digit1,digit0} 3-bit character codes of the last accepted frame.
REQ-008 ERR  output  4  per-digit flag, 1 = captured pattern not in the character table.
REQ-009 FRAME_VALID  output  1  frame available; held until accepted.
REQ-010 OVR  output  1  sticky overflow flag.

Function
REQ-011 The character table SHALL be: 0001001->000 (H), 0000110->001 (E), 1000111->010 (L), 1000000->011 (O), 1111111->111 (blank, ERR=0); any other pattern SHALL give code 111 with ERR=1.
REQ-012 The settle FSM SHALL have states IDLE, SETTLE and LOCKED.
REQ-013 In IDLE, a one-hot DIG SHALL load the sample register with {DIG,SEG}, set the counter to 1 and enter SETTLE.
REQ-014 In SETTLE, a sample equal to the stored one SHALL increment the counter.
REQ-015 In SETTLE, a differing one-hot sample SHALL reload the register with counter=1; a non-one-hot DIG SHALL return the FSM to IDLE.
REQ-016 The edge on which the counter reaches STABLE_CNT SHALL capture the code and ERR into that digit's slot, set its captured-mask bit and enter LOCKED.
REQ-017 LOCKED SHALL persist while {DIG,SEG} is unchanged (no re-capture); any change SHALL act as the IDLE rule on that same edge.
REQ-018 Minimum capture latency SHALL be STABLE_CNT edges from the first sample of a stable {DIG,SEG}.
REQ-019 Re-capture of a digit already in the mask before frame completion SHALL overwrite its slot.
REQ-020 On the edge where the mask becomes 1111, the block SHALL clear the mask and complete the frame.
REQ-021 If FRAME_VALID is 0, or FRAME_READY is 1 on that edge, frame completion SHALL load CHAR/ERR and set FRAME_VALID=1 on the same edge.
REQ-022 If FRAME_VALID=1 and FRAME_READY=0 on the completing edge, the new frame SHALL be dropped (CHAR/ERR unchanged) and OVR set.
REQ-023 Acceptance without a completing frame SHALL clear FRAME_VALID on that edge; CHAR/ERR SHALL hold their values.
REQ-024 CHAR/ERR SHALL change only on a frame load.
REQ-025 OVR SHALL clear only on reset.
REQ-026 A SEG change inside a DIG window SHALL restart settling and SHALL NOT capture the intermediate glitch.

Reset
REQ-027 On KEY0=0 the block SHALL asynchronously set: FSM=IDLE, counter=0, mask=0000, all slots=111, CHAR=111111111111, ERR=0000, FRAME_VALID=0, OVR=0.
REQ-028 Reset mid-frame SHALL discard all partial captures; after release, capture SHALL restart from IDLE on the next rising edge.

Structure
REQ-029 A shared package SHALL hold the character-code constants (H, E, L, O, BLANK), the four segment-pattern constants, the FSM state type and the STABLE_CNT default.
REQ-030 The pattern-to-code lookup SHALL be a separate combinational sub-module, seg_char_decode (7-bit in; 3-bit code and err out), reused by the display-side encoder tests.

Verification
REQ-031 Scan DIG=0001/0010/0100/1000 with SEG = H, E, L, O patterns, 8 cycles each, FRAME_READY=1 -> FRAME_VALID pulses, CHAR=011_010_001_000, ERR=0000.
REQ-032 Digit1 held 3 cycles then DIG=0000, with STABLE_CNT=4 -> no capture; mask bit1 stays 0 and no frame is produced.
REQ-033 Digit2 SEG=0101010 stable for 6 cycles within an otherwise valid scan -> digit2 code 111, ERR=0100.
REQ-034 FRAME_READY=0 through two complete scans -> first frame held, OVR=1, CHAR unchanged; raising FRAME_READY clears FRAME_VALID on the next edge.
REQ-035 Assert KEY0=0 mid-clock after 3 digits captured -> outputs immediately at reset values; after release, a full new 4-digit scan is needed for a frame.
REQ-036 FRAME_READY=1 on the same edge a second frame completes -> FRAME_VALID stays 1, CHAR shows the second frame, OVR=0.
